// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Microcoded control unit for the 8-bit computer. A T-state counter steps
//   through the fetch (T0,T1) and execute (T2..T4) microsteps of every
//   instruction. The control word is a combinational function of opcode,
//   microstep and the Z/C flags; the only state is the step counter and the
//   RUN/HALT state.
//
//   Optional feature (compile-time macro EARLY_END_EN):
//     defined   - STEP returns to 0 right after the last non-empty microstep
//     undefined - every instruction takes exactly STEPS cycles
//
// Ports
//   clk     in   1       system clock, rising edge
//   rst     in   1       asynchronous active-high reset
//   INSTR   in   4       opcode (upper nibble of instruction register)
//   FZ      in   1       zero flag from flag_register
//   FC      in   1       carry flag from flag_register
//   CTRL    out  16      {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI}
//   STEP    out  STEP_W  current microstep
//   HALTED  out  1       high while in HALT state
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int STEPS  = 5,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        INSTR,
  input  logic              FZ,
  input  logic              FC,
  output logic [15:0]       CTRL,
  output logic [STEP_W-1:0] STEP,
  output logic              HALTED
);

  // Control word bit masks
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_HLT  = STEP_W'(2);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            state_q;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] end_step_s;
  logic [15:0]       ctrl_d;

`ifdef EARLY_END_EN
  // Last non-empty microstep per opcode; undefined opcodes behave as NOP.
  function automatic logic [STEP_W-1:0] last_step(input logic [3:0] op);
    logic [STEP_W-1:0] r;
    case (op)
      4'h1, 4'h4:                      r = STEP_W'(3);
      4'h2, 4'h3:                      r = STEP_W'(4);
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE:    r = STEP_W'(2);
      4'hF:                            r = STEP_LAST; // halts at T2 anyway
      default:                         r = STEP_W'(1);
    endcase
    return r;
  endfunction

  assign end_step_s = last_step(INSTR);
`else
  assign end_step_s = STEP_LAST;
`endif

  // Microcode decode: control word from state, step, opcode and flags
  always_comb begin
    ctrl_d = 16'h0000;
    if (state_q == S_HALT) begin
      ctrl_d = C_HLT;
    end else begin
      case (step_q)
        STEP_W'(0): ctrl_d = C_CO | C_MI;
        STEP_W'(1): ctrl_d = C_RO | C_II | C_CE;
        STEP_W'(2): begin
          case (INSTR)
            4'h1, 4'h2, 4'h3, 4'h4: ctrl_d = C_IO | C_MI;
            4'h5:                   ctrl_d = C_IO | C_AI;
            4'h6:                   ctrl_d = C_IO | C_J;
            4'h7:                   ctrl_d = FC ? (C_IO | C_J) : 16'h0000;
            4'h8:                   ctrl_d = FZ ? (C_IO | C_J) : 16'h0000;
            4'hE:                   ctrl_d = C_AO | C_OI;
            4'hF:                   ctrl_d = C_HLT;
            default:                ctrl_d = 16'h0000;
          endcase
        end
        STEP_W'(3): begin
          case (INSTR)
            4'h1:       ctrl_d = C_RO | C_AI;
            4'h2, 4'h3: ctrl_d = C_RO | C_BI;
            4'h4:       ctrl_d = C_AO | C_RI;
            default:    ctrl_d = 16'h0000;
          endcase
        end
        STEP_W'(4): begin
          case (INSTR)
            4'h2:    ctrl_d = C_EO | C_AI | C_FI;
            4'h3:    ctrl_d = C_EO | C_AI | C_SU | C_FI;
            default: ctrl_d = 16'h0000;
          endcase
        end
        default: ctrl_d = 16'h0000;
      endcase
    end
  end

  // RUN/HALT state machine and microstep counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      step_q  <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if ((INSTR == 4'hF) && (step_q == STEP_HLT)) begin
            state_q <= S_HALT;          // step stays frozen at T2
          end else if ((step_q == end_step_s) || (step_q >= STEP_LAST)) begin
            step_q <= '0;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_RUN;
          step_q  <= '0;
        end
      endcase
    end
  end

  assign CTRL   = ctrl_d;
  assign STEP   = step_q;
  assign HALTED = (state_q == S_HALT);

endmodule
